// File: rtl/fp16_quant_unit_if.sv
// Stream bundle for fp16_quant_unit: the FP16 input beat (activation plus
// inverse scale) and the quantized output beat, each with valid/ready.
//   in_valid/in_ready          input handshake
//   fp16_in, fp16_inv_scale    FP16 operands, sampled together
//   out_valid/out_ready        output handshake
//   int_out                    signed OUT_W-bit quantized result
//   sat_flag, nan_flag         per-beat status
// slave = the quantizer's view; master = the surrounding logic's view.
interface fp16_quant_unit_if #(
  parameter int OUT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      fp16_in;
  logic [15:0]      fp16_inv_scale;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] int_out;
  logic             sat_flag;
  logic             nan_flag;

  modport slave (
    input  in_valid, fp16_in, fp16_inv_scale, out_ready,
    output in_ready, out_valid, int_out, sat_flag, nan_flag
  );

  modport master (
    output in_valid, fp16_in, fp16_inv_scale, out_ready,
    input  in_ready, out_valid, int_out, sat_flag, nan_flag
  );
endinterface

// File: rtl/fp16_quant_unit.sv
// FP16 quantizer: int_out = sat(round_half_away(fp16_in * fp16_inv_scale)).
// Three pipeline stages (decode+multiply, shift+round, saturate) that advance
// together unless the output beat is stalled; plus a saturated-beat counter.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   bus          stream interface (slave modport), see fp16_quant_unit_if
//   clr_stats    clears sat_cnt (wins over a same-cycle increment)
//   sat_cnt      saturating count of handshaked beats with sat_flag set
module fp16_quant_unit #(
  parameter int OUT_W     = 8,
  parameter bit SYMMETRIC = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  fp16_quant_unit_if.slave   bus,
  input  logic               clr_stats,
  output logic [15:0]        sat_cnt
);

  localparam logic [32:0] PosMax = (33'd1 << (OUT_W - 1)) - 33'd1;
  localparam logic [32:0] NegMax = SYMMETRIC ? PosMax : PosMax + 33'd1;

  logic stall;
  logic v1_q, v2_q, v3_q;

  assign stall        = v3_q & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  // ---------------- S1: decode + multiply ----------------
  logic [4:0]  xe, se, xe_eff, se_eff;
  logic [9:0]  xf, sf;
  logic [10:0] xm, sm;
  logic        x_nan, s_nan, x_inf, s_inf, x_zero, s_zero;
  logic        nan1_d, inf1_d, zero1_d;
  logic [21:0] p1_d;
  logic signed [6:0] sh1_d;

  assign xe = bus.fp16_in[14:10];
  assign xf = bus.fp16_in[9:0];
  assign se = bus.fp16_inv_scale[14:10];
  assign sf = bus.fp16_inv_scale[9:0];

  assign x_nan  = (xe == 5'h1F) && (xf != '0);
  assign s_nan  = (se == 5'h1F) && (sf != '0);
  assign x_inf  = (xe == 5'h1F) && (xf == '0);
  assign s_inf  = (se == 5'h1F) && (sf == '0);
  assign x_zero = (xe == '0) && (xf == '0);
  assign s_zero = (se == '0) && (sf == '0);

  // Inf x 0 has no meaningful magnitude, so it is reported as NaN.
  assign nan1_d  = x_nan | s_nan | (x_inf & s_zero) | (s_inf & x_zero);
  assign inf1_d  = (x_inf | s_inf) & ~nan1_d;
  assign zero1_d = (x_zero | s_zero) & ~nan1_d;

  assign xm     = {xe != '0, xf};
  assign sm     = {se != '0, sf};
  assign xe_eff = (xe == '0) ? 5'd1 : xe;
  assign se_eff = (se == '0) ? 5'd1 : se;
  assign p1_d   = xm * sm;
  // Product of two 1.10 mantissas is 2.20; biases 15+15 plus 20 fraction bits.
  assign sh1_d  = $signed({2'b00, xe_eff}) + $signed({2'b00, se_eff}) - 7'sd50;

  logic [21:0]       p1_q;
  logic signed [6:0] sh1_q;
  logic              sign1_q, nan1_q, inf1_q, zero1_q;

  // ---------------- S2: shift + round ----------------
  logic [6:0]  nsh;
  logic [22:0] rnd;
  logic [32:0] mag2_d;

  always_comb begin
    nsh    = 7'(-sh1_q);
    rnd    = '0;
    mag2_d = '0;
    if (!sh1_q[6]) begin
      mag2_d = {11'd0, p1_q} << sh1_q[5:0];
    end else if (nsh <= 7'd22) begin
      // Adding half an output LSB before truncating rounds the magnitude
      // half away from zero; the sign is reapplied afterwards.
      rnd    = {1'b0, p1_q} + (23'd1 << (nsh - 7'd1));
      mag2_d = {10'd0, rnd >> nsh};
    end
  end

  logic [32:0] mag2_q;
  logic        sign2_q, nan2_q, inf2_q, zero2_q;

  // ---------------- S3: saturate ----------------
  logic [32:0]      lim;
  logic [OUT_W-1:0] res_d;
  logic             sat_d, nan_d;

  assign lim = sign2_q ? NegMax : PosMax;

  always_comb begin
    res_d = '0;
    sat_d = 1'b0;
    nan_d = 1'b0;
    if (v2_q) begin
      if (nan2_q) begin
        nan_d = 1'b1;
      end else if (inf2_q || (mag2_q > lim)) begin
        sat_d = 1'b1;
        res_d = sign2_q ? OUT_W'(-lim[OUT_W-1:0]) : lim[OUT_W-1:0];
      end else if (!zero2_q) begin
        res_d = sign2_q ? OUT_W'(-mag2_q[OUT_W-1:0]) : mag2_q[OUT_W-1:0];
      end
    end
  end

  logic [OUT_W-1:0] int_out_q;
  logic             sat_q, nan_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      p1_q      <= '0;
      sh1_q     <= '0;
      sign1_q   <= 1'b0;
      nan1_q    <= 1'b0;
      inf1_q    <= 1'b0;
      zero1_q   <= 1'b0;
      mag2_q    <= '0;
      sign2_q   <= 1'b0;
      nan2_q    <= 1'b0;
      inf2_q    <= 1'b0;
      zero2_q   <= 1'b0;
      int_out_q <= '0;
      sat_q     <= 1'b0;
      nan_q     <= 1'b0;
    end else if (!stall) begin
      v1_q      <= bus.in_valid;
      p1_q      <= p1_d;
      sh1_q     <= sh1_d;
      sign1_q   <= bus.fp16_in[15] ^ bus.fp16_inv_scale[15];
      nan1_q    <= nan1_d;
      inf1_q    <= inf1_d;
      zero1_q   <= zero1_d;
      v2_q      <= v1_q;
      mag2_q    <= mag2_d;
      sign2_q   <= sign1_q;
      nan2_q    <= nan1_q;
      inf2_q    <= inf1_q;
      zero2_q   <= zero1_q;
      v3_q      <= v2_q;
      int_out_q <= res_d;
      sat_q     <= sat_d;
      nan_q     <= nan_d;
    end
  end

  assign bus.out_valid = v3_q;
  assign bus.int_out   = int_out_q;
  assign bus.sat_flag  = sat_q;
  assign bus.nan_flag  = nan_q;

  // ---------------- saturation event counter ----------------
  logic [15:0] sat_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      sat_cnt_q <= '0;
    end else if (v3_q && bus.out_ready && sat_q && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_cnt = sat_cnt_q;

endmodule

// File: doc/fp16_quant_unit.md
Name: fp16_quant_unit

Overview:
- Quantizer: multiplies an FP16 activation by an FP16 inverse scale, rounds to nearest (half away from zero) and saturates to a signed OUT_W-bit integer.
- Inverse of the INT32×FP16→FP16 dequant scale unit in the PE. Sits on the PE input side and feeds quantized operands to the integer MAC array.
- 3-stage pipeline with valid/ready flow control, plus a saturation event counter.

Parameters:
- OUT_W, 8, output integer width (4..16).
- SYMMETRIC, 1, 1: negative clamp is -(2^(OUT_W-1)-1); 0: negative clamp is -2^(OUT_W-1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  pipeline can accept a beat.
- fp16_in  in  16  FP16 activation.
- fp16_inv_scale  in  16  FP16 inverse scale, sampled with each beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- int_out  out  OUT_W  signed quantized result.
- sat_flag  out  1  this beat was clamped (overflow, or Inf input).
- nan_flag  out  1  either operand was NaN; int_out is 0.
- clr_stats  in  1  clears sat_cnt.
- sat_cnt  out  16  count of saturated beats; saturates at 0xFFFF.

Behaviour:
- Reset (rst high at a clk edge): all stage valids 0, so out_valid=0. int_out=0, sat_flag=0, nan_flag=0, sat_cnt=0. Beats in flight are discarded.
- Flow control:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational.
  - On stall, all stages hold.
  - Otherwise every stage advances one position; empty slots advance as bubbles. Bubbles are not collapsed.
  - A beat is accepted when in_valid & in_ready.
- Latency: exactly 3 cycles from acceptance to out_valid with no stalls. Full throughput is 1 beat/cycle.
- S1 decode + multiply:
  - Mantissa: m = {exp!=0, frac}.
  - Effective exponent: e = max(exp,1).
  - P = mx*ms, 22 bits.
  - sh = ex+es-50, signed 7-bit.
  - sign = sx^ss.
  - Classify:
    - NaN: exp=31 and frac!=0, on either operand.
    - Inf: exp=31 and frac=0, on either operand with no NaN.
    - Zero: either magnitude is 0.
  - Inf×0 is treated as NaN.
- S2 shift + round:
  - sh>=0: mag = P<<sh in a 33-bit field (max sh=10).
  - -22<=sh<0: mag = (P + 2^(-sh-1)) >> -sh, i.e. round half away from zero.
  - sh<-22: mag = 0.
- S3 saturate + register:
  - Limits: posmax = 2^(OUT_W-1)-1; negmax = posmax if SYMMETRIC, else posmax+1.
  - Inf or mag>limit: output is ±limit by sign, sat_flag=1.
  - NaN: output 0, nan_flag=1, sat_flag=0.
  - Zero: output 0 with no flags. The result is always 0, never -0.
  - Otherwise: output sign ? -mag : mag.
- sat_cnt:
  - Increments on each output handshake (out_valid & out_ready) with sat_flag=1.
  - Holds at 0xFFFF.
  - clr_stats has priority: it forces 0, and an increment in the same cycle is dropped.
- Inputs are ignored when not accepted. The output holds stable while out_valid & ~out_ready.

Test Plan:
- Rounding: fp16_in=0x3C00 (1.0), scale=0x3C00 → 1. 0x4100 (2.5) → 3. 0xC100 (-2.5) → -3. 0x3666 (≈0.4) → 0. Each appears 3 cycles after acceptance, with no flags.
- Saturation: 0x5640 (100) × 0x4000 (2.0) → 127, sat_flag=1. 0xDA40 (-200) × 0x3C00 → -127 with SYMMETRIC=1, or -128 with SYMMETRIC=0. sat_cnt=2 after both handshakes.
- Specials:
  - 0x7C00 × 0x3C00 → 127, sat_flag=1.
  - 0x7E00 × any → 0, nan_flag=1.
  - 0x7C00 × 0x0000 → 0, nan_flag=1.
  - 0x0001 (subnormal) × 0x3C00 → 0.
  - 0x8000 × 0x3C00 → 0.
- Backpressure: stream 10 beats with out_ready toggling 1,0,0,1,… → every beat appears once, in order, with values unchanged; in_ready=0 exactly when out_valid & ~out_ready.
- Reset mid-stream: assert rst with 3 beats in flight → next cycle out_valid=0 and sat_cnt=0, and no stale beats appear after rst is released.
- Counter: 65540 consecutive saturating beats → sat_cnt=0xFFFF. Pulse clr_stats together with a saturating handshake → sat_cnt=0.
